alu_exec: RTL

//  Execution unit on the consumer side of the RS->ALU issue interface. It accepts
//  at most one ready op per cycle from the reservation station, computes it in
//  LAT pipeline stages, and drives the CDB result (val_flag_RS/val_idx_RS/val_RS).
//  RS, LSB and ROB snoop that broadcast. Branch and JALR outcomes also go to the ROB.

---
 rtl/alu_exec.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/alu_exec.sv
// Pipelined integer execution unit fed by the reservation station; broadcasts
// results and branch/JALR outcomes on the CDB after LAT registered stages.
module alu_exec #(
  parameter int LAT   = 2,
  parameter int ROB_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             jp_wrong,
  input  logic             ari_ins_flag,
  input  logic [5:0]       ari_insty,
  input  logic [31:0]      ari_val1,
  input  logic [31:0]      ari_val2,
  input  logic [ROB_W-1:0] ari_ROB_idx,
  output logic             val_flag_RS,
  output logic [ROB_W-1:0] val_idx_RS,
  output logic [31:0]      val_RS,
  output logic             br_flag,
  output logic             br_taken,
  output logic [31:0]      br_target
);

  localparam logic [5:0] OP_LUI  = 6'd1,  OP_JALR = 6'd4;
  localparam logic [5:0] OP_BEQ  = 6'd5,  OP_BNE  = 6'd6,  OP_BLT  = 6'd7;
  localparam logic [5:0] OP_BGE  = 6'd8,  OP_BLTU = 6'd9,  OP_BGEU = 6'd10;
  localparam logic [5:0] OP_ADDI = 6'd19, OP_SLTI = 6'd20, OP_SLTIU = 6'd21;
  localparam logic [5:0] OP_XORI = 6'd22, OP_ORI  = 6'd23, OP_ANDI = 6'd24;
  localparam logic [5:0] OP_SLLI = 6'd25, OP_SRLI = 6'd26, OP_SRAI = 6'd27;
  localparam logic [5:0] OP_ADD  = 6'd28, OP_SUB  = 6'd29, OP_SLL  = 6'd30;
  localparam logic [5:0] OP_SLT  = 6'd31, OP_SLTU = 6'd32, OP_XOR  = 6'd33;
  localparam logic [5:0] OP_SRL  = 6'd34, OP_SRA  = 6'd35, OP_OR   = 6'd36;
  localparam logic [5:0] OP_AND  = 6'd37;

  // Operands feeding the result stage: raw inputs for LAT=1, stage-1 regs for LAT=2.
  logic             src_valid;
  logic [5:0]       src_op;
  logic [31:0]      src_a;
  logic [31:0]      src_b;
  logic [ROB_W-1:0] src_idx;

  generate
    if (LAT == 1) begin : g_lat1
      assign src_valid = ari_ins_flag;
      assign src_op    = ari_insty;
      assign src_a     = ari_val1;
      assign src_b     = ari_val2;
      assign src_idx   = ari_ROB_idx;
    end else begin : g_lat2
      logic             s1_valid;
      logic [5:0]       s1_op;
      logic [31:0]      s1_a;
      logic [31:0]      s1_b;
      logic [ROB_W-1:0] s1_idx;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_valid <= 1'b0;
          s1_op    <= '0;
          s1_a     <= '0;
          s1_b     <= '0;
          s1_idx   <= '0;
        end else if (rdy) begin
          s1_valid <= ari_ins_flag & ~jp_wrong;
          if (ari_ins_flag && !jp_wrong) begin
            s1_op  <= ari_insty;
            s1_a   <= ari_val1;
            s1_b   <= ari_val2;
            s1_idx <= ari_ROB_idx;
          end
        end
      end

      assign src_valid = s1_valid;
      assign src_op    = s1_op;
      assign src_a     = s1_a;
      assign src_b     = s1_b;
      assign src_idx   = s1_idx;
    end
  endgenerate

  logic [4:0]  shamt;
  logic [31:0] result;
  logic        is_br;
  logic        taken;
  logic [31:0] target;

  assign shamt = src_b[4:0];

  always_comb begin
    result = '0;
    is_br  = 1'b0;
    taken  = 1'b0;
    target = '0;
    case (src_op)
      OP_ADD,  OP_ADDI:  result = src_a + src_b;
      OP_SUB:            result = src_a - src_b;
      OP_XOR,  OP_XORI:  result = src_a ^ src_b;
      OP_OR,   OP_ORI:   result = src_a | src_b;
      OP_AND,  OP_ANDI:  result = src_a & src_b;
      OP_SLL,  OP_SLLI:  result = src_a << shamt;
      OP_SRL,  OP_SRLI:  result = src_a >> shamt;
      OP_SRA,  OP_SRAI:  result = $signed(src_a) >>> shamt;
      OP_SLT,  OP_SLTI:  result = {31'b0, $signed(src_a) < $signed(src_b)};
      OP_SLTU, OP_SLTIU: result = {31'b0, src_a < src_b};
      OP_LUI:            result = src_b;
      OP_BEQ:  begin is_br = 1'b1; taken = (src_a == src_b); end
      OP_BNE:  begin is_br = 1'b1; taken = (src_a != src_b); end
      OP_BLT:  begin is_br = 1'b1; taken = ($signed(src_a) <  $signed(src_b)); end
      OP_BGE:  begin is_br = 1'b1; taken = ($signed(src_a) >= $signed(src_b)); end
      OP_BLTU: begin is_br = 1'b1; taken = (src_a <  src_b); end
      OP_BGEU: begin is_br = 1'b1; taken = (src_a >= src_b); end
      OP_JALR: begin
        is_br  = 1'b1;
        taken  = 1'b1;
        target = (src_a + src_b) & 32'hFFFF_FFFE;
      end
      default: ;
    endcase
  end

  // Broadcast stage; data registers only move when a valid op lands so they hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_flag_RS <= 1'b0;
      val_idx_RS  <= '0;
      val_RS      <= '0;
      br_flag     <= 1'b0;
      br_taken    <= 1'b0;
      br_target   <= '0;
    end else if (rdy) begin
      if (jp_wrong) begin
        val_flag_RS <= 1'b0;
        br_flag     <= 1'b0;
      end else begin
        val_flag_RS <= src_valid;
        br_flag     <= src_valid & is_br;
        if (src_valid) begin
          val_idx_RS <= src_idx;
          val_RS     <= result;
          br_taken   <= taken;
          br_target  <= target;
        end
      end
    end
  end

endmodule
